// File: rtl/seq_divider_77x43.sv
// Iterative radix-2 restoring divider: Q = A / B, R = A % B, one quotient bit per cycle.
// Start/ready/done handshake; a zero divisor short-cuts straight to FIN with dz set.
module seq_divider_77x43 #(
    parameter int DW = 77,
    parameter int VW = 43,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] R,
    output logic          dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] d_q, d_d;
    logic [VW-1:0] v_q, v_d;
    logic [VW:0]   p_q, p_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic          dz_q, dz_d;

    // One restoring step; P carries a guard bit so the trial subtraction sign is its MSB.
    logic [VW:0]   shifted;
    logic [VW:0]   trial;
    logic [VW:0]   p_iter;
    logic [DW-1:0] d_iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            v_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            v_q     <= v_d;
            p_q     <= p_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = (B == '0) ? S_FIN : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shifted = {p_q[VW-1:0], d_q[DW-1]};
        trial   = shifted - {1'b0, v_q};
        p_iter  = trial[VW] ? shifted : trial;
        d_iter  = {d_q[DW-2:0], ~trial[VW]};

        cnt_d = cnt_q;
        d_d   = d_q;
        v_d   = v_q;
        p_d   = p_q;
        q_d   = q_q;
        r_d   = r_q;
        dz_d  = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    d_d   = A;
                    v_d   = B;
                    p_d   = '0;
                    cnt_d = CW'(DW - 1);
                    if (B == '0) begin
                        q_d  = '1;
                        r_d  = '0;
                        dz_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                d_d = d_iter;
                p_d = p_iter;
                if (cnt_q == '0) begin
                    // Results land on the FIN-entry edge so they are valid while done is high.
                    q_d  = d_iter;
                    r_d  = p_iter[VW-1:0];
                    dz_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE);
        done  = (state_q == S_FIN);
        Q     = q_q;
        R     = r_q;
        dz    = dz_q;
    end

endmodule
